// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one single-port Wishbone-style memory slave among NUM_M masters.
// Each grant holds the strobe until s_ack or timeout, then pulses the ack back to the winner only.
module wb_mem_arbiter #(
  parameter int NUM_M   = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_we,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_wdata,
  output logic [NUM_M-1:0]    m_gnt,
  output logic [NUM_M-1:0]    m_ack,
  output logic                m_err,
  output logic [DW-1:0]       m_rdata,
  output logic                s_strb,
  output logic                s_we,
  output logic [AW-1:0]       s_addr,
  output logic [DW-1:0]       s_wdata,
  input  logic [DW-1:0]       s_rdata,
  input  logic                s_ack
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [IW-1:0] last, g, pick, idx;
  logic          found;
  logic [CW-1:0] cnt;

  // First requester strictly after the last winner, wrapping around.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = IW'((int'(last) + k) % NUM_M);
      if (!found && m_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= IW'(NUM_M - 1);
      g       <= '0;
      cnt     <= '0;
      m_gnt   <= '0;
      m_ack   <= '0;
      m_err   <= 1'b0;
      m_rdata <= '0;
      s_strb  <= 1'b0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            g       <= pick;
            m_gnt   <= NUM_M'(1) << pick;
            s_strb  <= 1'b1;
            s_we    <= m_we[pick];
            s_addr  <= m_addr[pick*AW +: AW];
            s_wdata <= m_wdata[pick*DW +: DW];
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // A slave ack in the timeout cycle still counts as success.
          if (s_ack) begin
            m_rdata <= s_we ? '0 : s_rdata;
            m_ack   <= m_gnt;
            m_err   <= 1'b0;
            s_strb  <= 1'b0;
            state   <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            m_rdata <= '0;
            m_ack   <= m_gnt;
            m_err   <= 1'b1;
            s_strb  <= 1'b0;
            state   <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          last    <= g;
          m_gnt   <= '0;
          m_ack   <= '0;
          m_err   <= 1'b0;
          m_rdata <= '0;
          s_we    <= 1'b0;
          s_addr  <= '0;
          s_wdata <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Randomized bench for wb_mem_arbiter: memory slave model plus a round-robin/shadow-memory reference.
module tb_wb_mem_arbiter;
  localparam int NUM_M = 4, AW = 8, DW = 8, TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NUM_M-1:0]    req, we, hold;
  logic [AW-1:0]       addr_d [NUM_M];
  logic [DW-1:0]       wdata_d[NUM_M];
  logic [NUM_M*AW-1:0] m_addr;
  logic [NUM_M*DW-1:0] m_wdata;
  logic [NUM_M-1:0]    m_gnt, m_ack;
  logic                m_err, s_strb, s_we, s_ack;
  logic [DW-1:0]       m_rdata, s_wdata, s_rdata;
  logic [AW-1:0]       s_addr;

  // slave model: acks one cycle after seeing the strobe, unless held in reset
  logic          slv_rst, slv_ack, force_ack;
  logic [DW-1:0] slv_rdata, force_rdata;
  logic [DW-1:0] smem[256];

  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      m_addr[i*AW +: AW]  = addr_d[i];
      m_wdata[i*DW +: DW] = wdata_d[i];
    end
  end
  assign s_ack   = slv_ack | force_ack;
  assign s_rdata = force_ack ? force_rdata : slv_rdata;

  always @(posedge clk) begin
    if (slv_rst) slv_ack <= 1'b0;
    else if (s_strb && !slv_ack) begin
      slv_ack   <= 1'b1;
      slv_rdata <= smem[s_addr];
      if (s_we) smem[s_addr] <= s_wdata;
    end else slv_ack <= 1'b0;
  end

  wb_mem_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .m_req(req), .m_we(we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_strb(s_strb), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  // reference model state
  int            total = 0, bad = 0;
  int            mlast;
  logic [DW-1:0] shadow[256];
  logic          cmd_we   [NUM_M];
  logic [AW-1:0] cmd_addr [NUM_M];
  logic [DW-1:0] cmd_wdata[NUM_M];

  function automatic int rr_next(input logic [NUM_M-1:0] pend, input int lst);
    for (int k = 1; k <= NUM_M; k++)
      if (pend[(lst + k) % NUM_M]) return (lst + k) % NUM_M;
    return -1;
  endfunction

  function automatic logic [NUM_M-1:0] bit_of(input int i);
    logic [NUM_M-1:0] v;
    v = '0;
    if (i >= 0 && i < NUM_M) v[i] = 1'b1;
    return v;
  endfunction

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i] = w; addr_d[i] = a; wdata_d[i] = d;
    cmd_we[i] = w; cmd_addr[i] = a; cmd_wdata[i] = d;
    req[i] = 1'b1;
  endtask

  task automatic model_done(input int i, input logic timed_out, output logic [DW-1:0] exp);
    exp = '0;
    if (!timed_out) begin
      if (cmd_we[i]) shadow[cmd_addr[i]] = cmd_wdata[i];
      else exp = shadow[cmd_addr[i]];
    end
    mlast = i;
  endtask

  // waits for the next ack; granted masters' inputs are scrambled meanwhile
  task automatic wait_ack(input int maxc, output logic [NUM_M-1:0] ackv, output logic err,
                          output logic [DW-1:0] rd, output int cyc);
    ackv = '0; err = 1'b0; rd = '0; cyc = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (m_ack != '0) begin
        ackv = m_ack; err = m_err; rd = m_rdata; cyc = c;
        for (int i = 0; i < NUM_M; i++) if (m_ack[i] && !hold[i]) req[i] = 1'b0;
        return;
      end
      for (int i = 0; i < NUM_M; i++)
        if (m_gnt[i]) begin
          we[i] = 1'($urandom); addr_d[i] = AW'($urandom); wdata_d[i] = DW'($urandom);
        end
    end
  endtask

  task automatic test_reset();
    logic [34:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    v = {m_gnt, m_ack, m_err, m_rdata, s_strb, s_we, s_addr, s_wdata};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", v); end
    rst = 1'b0;
    mlast = NUM_M - 1;
  endtask

  task automatic test_write_read();
    logic [NUM_M-1:0] a; logic e; logic [DW-1:0] rd, exp; int cyc;
    repeat (2) @(negedge clk);
    issue(0, 1'b1, 8'h10, 8'hA5);
    wait_ack(12, a, e, rd, cyc);
    total++; if (a !== 4'b0001) begin bad++; $display("FAIL wr_ack got=%b want=0001", a); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", e); end
    total++; if (cyc != 3) begin bad++; $display("FAIL wr_latency got=%0d want=3", cyc); end
    model_done(0, 1'b0, exp);
    repeat (2) @(negedge clk);
    issue(0, 1'b0, 8'h10, 8'h00);
    wait_ack(12, a, e, rd, cyc);
    model_done(0, 1'b0, exp);
    total++; if (a !== 4'b0001) begin bad++; $display("FAIL rd_ack got=%b want=0001", a); end
    total++; if (rd !== exp || exp !== 8'hA5) begin bad++; $display("FAIL rd_data got=%h want=%h", rd, exp); end
  endtask

  task automatic test_all_four();
    logic [NUM_M-1:0] a, pend; logic e; logic [DW-1:0] rd, exp; int cyc, g;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NUM_M; i++)
      issue(i, 1'($urandom), AW'(i * 64 + $urandom_range(0, 63)), DW'($urandom));
    pend = '1;
    for (int n = 0; n < NUM_M; n++) begin
      g = rr_next(pend, mlast);
      wait_ack(12, a, e, rd, cyc);
      model_done(g, 1'b0, exp);
      pend[g] = 1'b0;
      total++; if (a !== bit_of(g)) begin bad++; $display("FAIL all4_order n=%0d got=%b want=%b", n, a, bit_of(g)); end
      total++; if (cyc != ((n == 0) ? 3 : 4)) begin bad++; $display("FAIL all4_spacing n=%0d got=%0d", n, cyc); end
      total++; if (e !== 1'b0 || rd !== exp) begin bad++; $display("FAIL all4_data n=%0d got=%h/%b want=%h/0", n, rd, e, exp); end
    end
    repeat (2) @(negedge clk);
    issue(1, 1'b0, AW'($urandom), 8'h00);
    issue(3, 1'b0, AW'($urandom), 8'h00);
    pend = 4'b1010;
    for (int n = 0; n < 2; n++) begin
      g = rr_next(pend, mlast);
      wait_ack(12, a, e, rd, cyc);
      model_done(g, 1'b0, exp);
      pend[g] = 1'b0;
      total++; if (a !== bit_of(g) || rd !== exp) begin bad++; $display("FAIL pair_order n=%0d got=%b/%h want=%b/%h", n, a, rd, bit_of(g), exp); end
    end
  endtask

  task automatic test_held();
    int exp_order[4];
    int nack, lowrun, g;
    logic prev, seen;
    logic [DW-1:0] exp;
    exp_order = '{2, 0, 2, 2};
    nack = 0; lowrun = 0; prev = 1'b0; seen = 1'b0;
    repeat (2) @(negedge clk);
    hold[2] = 1'b1;
    issue(2, 1'b0, AW'($urandom), 8'h00);
    @(negedge clk);
    if (s_strb) begin seen = 1'b1; prev = 1'b1; end
    issue(0, 1'b0, AW'($urandom), 8'h00);
    for (int c = 0; c < 60 && nack < 4; c++) begin
      @(negedge clk);
      if (s_strb && !prev && seen) begin
        total++; if (lowrun != 2) begin bad++; $display("FAIL held_gap got=%0d want=2", lowrun); end
      end
      if (s_strb) begin seen = 1'b1; lowrun = 0; end else lowrun++;
      prev = s_strb;
      if (m_ack != '0) begin
        g = exp_order[nack];
        total++; if (m_ack !== bit_of(g)) begin bad++; $display("FAIL held_order n=%0d got=%b want=%b", nack, m_ack, bit_of(g)); end
        model_done(g, 1'b0, exp);
        total++; if (m_rdata !== exp) begin bad++; $display("FAIL held_data n=%0d got=%h want=%h", nack, m_rdata, exp); end
        if (m_ack[0]) req[0] = 1'b0;
        nack++;
        if (nack == 4) begin hold[2] = 1'b0; req[2] = 1'b0; end
      end
    end
    hold = '0; req = '0;
    total++; if (nack != 4) begin bad++; $display("FAIL held_count got=%0d want=4", nack); end
  endtask

  task automatic test_timeout();
    logic [NUM_M-1:0] a; logic e; logic [DW-1:0] rd, exp; int cyc, rise, ackc;
    logic [AW-1:0] ad;
    a = '0; e = 1'b0; rd = '0; rise = -1; ackc = -1;
    slv_rst = 1'b1;
    ad = AW'($urandom);
    repeat (2) @(negedge clk);
    issue(1, 1'b0, ad, 8'h00);
    for (int c = 1; c <= 40 && ackc < 0; c++) begin
      @(negedge clk);
      if (s_strb && rise < 0) rise = c;
      if (m_ack != '0) begin a = m_ack; e = m_err; rd = m_rdata; ackc = c; req[1] = 1'b0; end
    end
    model_done(1, 1'b1, exp);
    total++; if (a !== 4'b0010 || e !== 1'b1) begin bad++; $display("FAIL to_ack got=%b err=%b want=0010 err=1", a, e); end
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL to_rdata got=%h want=00", rd); end
    total++; if (ackc - rise != TIMEOUT) begin bad++; $display("FAIL to_latency got=%0d want=%0d", ackc - rise, TIMEOUT); end
    slv_rst = 1'b0;
    repeat (2) @(negedge clk);
    issue(1, 1'b0, ad, 8'h00);
    wait_ack(12, a, e, rd, cyc);
    model_done(1, 1'b0, exp);
    total++; if (a !== 4'b0010 || e !== 1'b0 || rd !== exp) begin bad++; $display("FAIL to_recover got=%b/%b/%h want=0010/0/%h", a, e, rd, exp); end
  endtask

  task automatic test_stray_ack();
    logic [NUM_M-1:0] a; logic e; logic [DW-1:0] rd, val, exp;
    a = '0; e = 1'b1; rd = '0;
    repeat (2) @(negedge clk);
    force_ack = 1'b1; force_rdata = DW'($urandom);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) force_ack = 1'b0;
      total++; if (m_ack !== '0 || s_strb !== 1'b0) begin bad++; $display("FAIL stray_idle c=%0d ack=%b strb=%b want=0/0", c, m_ack, s_strb); end
    end
    slv_rst = 1'b1;
    val = DW'($urandom);
    issue(3, 1'b0, AW'($urandom), 8'h00);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == TIMEOUT) begin force_ack = 1'b1; force_rdata = val; end
      else force_ack = 1'b0;
      if (m_ack != '0) begin a = m_ack; e = m_err; rd = m_rdata; req[3] = 1'b0; break; end
    end
    force_ack = 1'b0; slv_rst = 1'b0;
    model_done(3, 1'b0, exp);
    total++; if (a !== 4'b1000 || e !== 1'b0) begin bad++; $display("FAIL race_ack got=%b err=%b want=1000 err=0", a, e); end
    total++; if (rd !== val) begin bad++; $display("FAIL race_rdata got=%h want=%h", rd, val); end
  endtask

  task automatic test_reset_mid();
    logic [NUM_M-1:0] a; logic e; logic [DW-1:0] rd, exp; int cyc, g;
    logic [34:0] v;
    logic any_ack;
    repeat (2) @(negedge clk);
    issue(0, 1'b0, AW'($urandom), 8'h00);
    wait_ack(12, a, e, rd, cyc);
    model_done(0, 1'b0, exp);
    total++; if (a !== 4'b0001 || rd !== exp) begin bad++; $display("FAIL mid_pre got=%b/%h want=0001/%h", a, rd, exp); end
    slv_rst = 1'b1;
    repeat (2) @(negedge clk);
    issue(2, 1'b1, AW'($urandom), DW'($urandom));
    repeat (3) @(negedge clk);
    total++; if (s_strb !== 1'b1 || m_gnt !== 4'b0100) begin bad++; $display("FAIL mid_busy strb=%b gnt=%b want=1/0100", s_strb, m_gnt); end
    rst = 1'b1; req = '0;
    @(negedge clk);
    v = {m_gnt, m_ack, m_err, m_rdata, s_strb, s_we, s_addr, s_wdata};
    total++; if (v !== '0) begin bad++; $display("FAIL mid_reset got=%h want=0", v); end
    rst = 1'b0; slv_rst = 1'b0; mlast = NUM_M - 1;
    any_ack = 1'b0;
    repeat (4) begin @(negedge clk); if (m_ack != '0) any_ack = 1'b1; end
    total++; if (any_ack !== 1'b0) begin bad++; $display("FAIL mid_noack got=%b want=0", any_ack); end
    issue(0, 1'b0, AW'($urandom), 8'h00);
    issue(3, 1'b0, AW'($urandom), 8'h00);
    for (int n = 0; n < 2; n++) begin
      g = rr_next((n == 0) ? 4'b1001 : 4'b1000, mlast);
      wait_ack(12, a, e, rd, cyc);
      model_done(g, 1'b0, exp);
      total++; if (a !== bit_of(g) || rd !== exp) begin bad++; $display("FAIL mid_prio n=%0d got=%b/%h want=%b/%h", n, a, rd, bit_of(g), exp); end
    end
  endtask

  task automatic test_random();
    logic [NUM_M-1:0] a, pend; logic e; logic [DW-1:0] rd, exp; int cyc, g;
    for (int it = 0; it < 25; it++) begin
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      pend = NUM_M'($urandom_range(1, (1 << NUM_M) - 1));
      for (int i = 0; i < NUM_M; i++)
        if (pend[i]) issue(i, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
      while (pend != '0) begin
        g = rr_next(pend, mlast);
        wait_ack(4 * NUM_M + 4, a, e, rd, cyc);
        model_done(g, 1'b0, exp);
        pend[g] = 1'b0;
        total++;
        if (a !== bit_of(g) || e !== 1'b0 || rd !== exp) begin
          bad++; $display("FAIL rand it=%0d got=%b/%b/%h want=%b/0/%h", it, a, e, rd, bit_of(g), exp);
          if (a == '0) return;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; hold = '0;
    slv_rst = 1'b0; force_ack = 1'b0; force_rdata = '0; mlast = NUM_M - 1;
    for (int i = 0; i < NUM_M; i++) begin
      addr_d[i] = '0; wdata_d[i] = '0;
      cmd_we[i] = 1'b0; cmd_addr[i] = '0; cmd_wdata[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      smem[i] = DW'(i * 3 + 7);
      shadow[i] = DW'(i * 3 + 7);
    end
    test_reset();
    test_write_read();
    test_all_four();
    test_held();
    test_timeout();
    test_stray_ack();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
